fft_sdf_stage_ctrl: RTL and testbench



---
 rtl/fft_sdf_stage_ctrl_if.sv | 40 ++++
 rtl/fft_sdf_stage_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fft_sdf_stage_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sdf_stage_ctrl_if.sv
// Handshake and datapath-control bundle for one radix-2 SDF FFT stage.
// Optional macro FFT_SDF_STAGE_CTRL_FRAME_CNT_EN adds the 16-bit frame_cnt signal.
interface fft_sdf_stage_ctrl_if #(
  parameter int HALF = 64,
  parameter int AW   = $clog2(HALF)
);
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [1:0]    mode;
  logic [AW-1:0] tw_addr;
  logic          dl_en;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic          busy;
`ifdef FFT_SDF_STAGE_CTRL_FRAME_CNT_EN
  logic [15:0]   frame_cnt;

  modport master (
    output in_valid, flush,
    input  in_ready, mode, tw_addr, dl_en, out_valid, out_first, out_last, busy, frame_cnt
  );

  modport slave (
    input  in_valid, flush,
    output in_ready, mode, tw_addr, dl_en, out_valid, out_first, out_last, busy, frame_cnt
  );
`else
  modport master (
    output in_valid, flush,
    input  in_ready, mode, tw_addr, dl_en, out_valid, out_first, out_last, busy
  );

  modport slave (
    input  in_valid, flush,
    output in_ready, mode, tw_addr, dl_en, out_valid, out_first, out_last, busy
  );
`endif
endinterface

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-delay-feedback FFT stage.
// Tracks the frame position of every accepted sample and decodes the delay-line
// enable, datapath mode, twiddle address and output framing with zero latency.
// Optional macro FFT_SDF_STAGE_CTRL_FRAME_CNT_EN adds a 16-bit completed-frame counter.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no frame in flight; first accepted sample starts a frame
// S_FILL  | first half of a frame is loading into the delay line
// S_BFLY  | second half arrives; butterfly sums leave the stage
// S_TWID  | stored differences leave rotated while the next frame loads
// S_DRAIN | input blocked; remaining differences leave rotated, then idle
module fft_sdf_stage_ctrl #(
  parameter int HALF = 64,
  parameter int AW   = $clog2(HALF)
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_sdf_stage_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_BFLY  = 3'd2,
    S_TWID  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [AW-1:0] IDX_LAST = AW'(HALF - 1);
  localparam logic [1:0]    MODE_LOAD = 2'd0;
  localparam logic [1:0]    MODE_BFLY = 2'd1;
  localparam logic [1:0]    MODE_ROT  = 2'd2;

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          flush_pend, flush_pend_nxt;

  logic          in_ready;
  logic          acc;
  logic          idx_last;
  logic [1:0]    mode;
  logic [AW-1:0] tw_addr;
  logic          dl_en;
  logic          out_valid;
  logic          out_first;
  logic          out_last;

  // State, index and pending-flush registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  // Sample acceptance; rst gating keeps in_valid from reaching dl_en during reset
  always_comb begin
    in_ready = (state != S_DRAIN);
    acc      = bus.in_valid & in_ready & ~rst;
    idx_last = (idx == IDX_LAST);
  end

  // Next-state and output decode from registered state plus in_valid
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    flush_pend_nxt = flush_pend;
    mode           = MODE_LOAD;
    tw_addr        = '0;
    dl_en          = 1'b0;
    out_valid      = 1'b0;
    out_first      = 1'b0;
    out_last       = 1'b0;

    case (state)
      S_IDLE: begin
        dl_en = acc;
        if (acc) begin
          idx_nxt   = AW'(1);
          state_nxt = S_FILL;
        end
      end

      S_FILL: begin
        // A flush aborts the partial frame and drops any sample offered with it
        if (bus.flush) begin
          idx_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          dl_en = acc;
          if (acc) begin
            idx_nxt = idx + AW'(1);
            if (idx_last) state_nxt = S_BFLY;
          end
        end
      end

      S_BFLY: begin
        mode      = MODE_BFLY;
        dl_en     = acc;
        out_valid = acc;
        out_first = acc & (idx == '0);
        if (bus.flush) flush_pend_nxt = 1'b1;
        if (acc) begin
          idx_nxt = idx + AW'(1);
          if (idx_last) state_nxt = (flush_pend | bus.flush) ? S_DRAIN : S_TWID;
        end
      end

      S_TWID: begin
        mode      = MODE_ROT;
        tw_addr   = idx;
        dl_en     = acc;
        out_valid = acc;
        out_last  = acc & idx_last;
        if (bus.flush) flush_pend_nxt = 1'b1;
        if (acc) begin
          idx_nxt = idx + AW'(1);
          if (idx_last) state_nxt = S_BFLY;
        end
      end

      S_DRAIN: begin
        mode      = MODE_ROT;
        tw_addr   = idx;
        dl_en     = 1'b1;
        out_valid = 1'b1;
        out_last  = idx_last;
        idx_nxt   = idx + AW'(1);
        if (idx_last) begin
          flush_pend_nxt = 1'b0;
          state_nxt      = S_IDLE;
        end
      end

      default: begin
        idx_nxt        = '0;
        flush_pend_nxt = 1'b0;
        state_nxt      = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.mode      = mode;
  assign bus.tw_addr   = tw_addr;
  assign bus.dl_en     = dl_en;
  assign bus.out_valid = out_valid;
  assign bus.out_first = out_first;
  assign bus.out_last  = out_last;
  assign bus.busy      = (state != S_IDLE);

`ifdef FFT_SDF_STAGE_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  // Completed output frames; aborts and resets never raise out_last
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           frame_cnt <= 16'd0;
    else if (out_last) frame_cnt <= frame_cnt + 16'd1;
  end

  assign bus.frame_cnt = frame_cnt;
`endif

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Self-checking bench for fft_sdf_stage_ctrl.
// The reference model tracks how many samples of the current stream have been
// accepted and derives every output from that count with plain arithmetic.
module tb_fft_sdf_stage_ctrl;
  localparam int HALF = 64;
  localparam int AW   = $clog2(HALF);

  logic clk;
  logic rst;

  fft_sdf_stage_ctrl_if #(.HALF(HALF), .AW(AW)) bus ();

  fft_sdf_stage_ctrl #(.HALF(HALF), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: stream active flag, accepted samples in stream, pending flush,
  // drain position (-1 when not draining), completed frames
  int m_active = 0;
  int m_pos    = 0;
  int m_pend   = 0;
  int m_drain  = -1;
  int m_frames = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_pos    = 0;
    m_pend   = 0;
    m_drain  = -1;
    m_frames = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  1);
    check({tag, "_mode"},      32'(bus.mode),      0);
    check({tag, "_tw_addr"},   32'(bus.tw_addr),   0);
    check({tag, "_dl_en"},     32'(bus.dl_en),     0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_first"}, 32'(bus.out_first), 0);
    check({tag, "_out_last"},  32'(bus.out_last),  0);
    check({tag, "_busy"},      32'(bus.busy),      0);
`ifdef FFT_SDF_STAGE_CTRL_FRAME_CNT_EN
    check({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 0);
`endif
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model
  task automatic step(input logic iv, input logic fl);
    int e_ready, e_mode, e_tw, e_dl, e_ov, e_first, e_last, e_busy;
    int acc, seg, off;
    @(negedge clk);
    bus.in_valid = iv;
    bus.flush    = fl;
    #1;
    e_ready = 1; e_mode = 0; e_tw = 0; e_dl = 0;
    e_ov = 0; e_first = 0; e_last = 0;
    e_busy = (m_active != 0 || m_drain >= 0) ? 1 : 0;
    seg = 0; off = 0;
    if (m_drain >= 0) begin
      e_ready = 0; e_mode = 2; e_tw = m_drain; e_dl = 1; e_ov = 1;
      e_last = (m_drain == HALF - 1) ? 1 : 0;
    end
    acc = (iv && e_ready != 0) ? 1 : 0;
    if (m_drain < 0) begin
      if (m_active == 0) begin
        e_dl = acc;
      end else if (m_pos < HALF) begin
        e_dl = (acc != 0 && !fl) ? 1 : 0;
      end else begin
        seg = (m_pos - HALF) / HALF;
        off = (m_pos - HALF) % HALF;
        e_dl = acc;
        e_ov = acc;
        if (seg % 2 == 0) begin
          e_mode  = 1;
          e_first = (acc != 0 && off == 0) ? 1 : 0;
        end else begin
          e_mode = 2;
          e_tw   = off;
          e_last = (acc != 0 && off == HALF - 1) ? 1 : 0;
        end
      end
    end

    check("in_ready",  32'(bus.in_ready),  e_ready);
    check("mode",      32'(bus.mode),      e_mode);
    check("tw_addr",   32'(bus.tw_addr),   e_tw);
    check("dl_en",     32'(bus.dl_en),     e_dl);
    check("out_valid", 32'(bus.out_valid), e_ov);
    check("out_first", 32'(bus.out_first), e_first);
    check("out_last",  32'(bus.out_last),  e_last);
    check("busy",      32'(bus.busy),      e_busy);
`ifdef FFT_SDF_STAGE_CTRL_FRAME_CNT_EN
    check("frame_cnt", 32'(bus.frame_cnt), m_frames % 65536);
`endif

    if (e_last != 0) m_frames++;
    if (m_drain >= 0) begin
      m_drain++;
      if (m_drain == HALF) begin
        m_drain = -1;
        m_pend  = 0;
      end
    end else if (m_active == 0) begin
      if (acc != 0) begin
        m_active = 1;
        m_pos    = 1;
      end
    end else if (m_pos < HALF) begin
      if (fl) begin
        m_active = 0;
        m_pos    = 0;
      end else if (acc != 0) begin
        m_pos++;
      end
    end else begin
      if (fl) m_pend = 1;
      if (acc != 0) begin
        if (seg % 2 == 0 && off == HALF - 1 && m_pend != 0) begin
          m_active = 0;
          m_pos    = 0;
          m_drain  = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  // n contiguous samples; flush pulsed on sample index fl_at (-1 for none)
  task automatic stream(input int n, input int fl_at);
    for (int i = 0; i < n; i++) step(1'b1, (i == fl_at));
  endtask

  task automatic idle_cycles(input int n, input logic iv);
    for (int i = 0; i < n; i++) step(iv, 1'b0);
  endtask

  // Async reset between clock edges, checked before any edge arrives
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs({tag, "_async"});
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // single frame, flush at BFLY idx 5, full drain, then idle
    stream(128, HALF + 5);
    idle_cycles(HALF, 1'b1);
    idle_cycles(2, 1'b0);

    // back-to-back streaming, flush in the second BFLY half
    stream(256, 200);
    idle_cycles(HALF + 2, 1'b0);

    // stall at BFLY idx 10 for 5 cycles
    stream(HALF + 10, -1);
    idle_cycles(5, 1'b0);
    stream(HALF - 10, 20);
    idle_cycles(HALF + 1, 1'b0);

    // flush during FILL idx 20 with a sample offered, then a normal frame
    stream(20, -1);
    step(1'b1, 1'b1);
    idle_cycles(3, 1'b0);
    stream(128, HALF + 5);
    idle_cycles(HALF + 1, 1'b0);

    // reset mid-drain at idx 30, then a full frame as before
    stream(128, HALF + 5);
    idle_cycles(30, 1'b0);
    async_reset("drain30");
    stream(128, HALF + 5);
    idle_cycles(HALF + 2, 1'b0);

    // three streamed frames plus flush
    stream(HALF * 6 + HALF, HALF * 6 + 3);
    idle_cycles(HALF + 1, 1'b0);

    // randomized traffic with occasional flushes and one mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 3));
      if (i == 1500) async_reset("rand");
    end
    idle_cycles(HALF + 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
